uc: RTL and testbench
=====================

UC -- requirements
Module: uc

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-003 The block SHALL have the port Opcode, input, 6 bits, the instruction bits [15:10] from the datapath.
REQ-004 The block SHALL have the port zero, input, 1 bit, the registered zero flag from the datapath.
REQ-005 The block SHALL have the port run, input, 1 bit: 1 = free-run, 0 = debug single-step mode.
REQ-006 The block SHALL have the port step, input, 1 bit, the single-step request level.
REQ-007 The block SHALL have the port s_inc, output, 1 bit: 1 = PC+1, 0 = load jump address.
REQ-008 The block SHALL have the port s_inm, output, 1 bit, the immediate-operand select.
REQ-009 The block SHALL have the ports we3 and wez, outputs, 1 bit each: register-file write enable and zero-flag write enable.
REQ-010 The block SHALL have the port ALUOp, output, 3 bits, the ALU operation.
REQ-011 The block SHALL have the port pc_en, output, 1 bit, the program-counter update enable.
REQ-012 The block SHALL have the ports halted and step_ack, outputs, 1 bit each.
REQ-013 The block SHALL have the port instr_cnt, output, 16 bits, the count of retired instructions.

Function
REQ-014 States SHALL be RST_WAIT, RUN, STEP_WAIT, STEP_EXEC and HALT.
REQ-015 The executing states SHALL be RUN and STEP_EXEC; every other state SHALL drive the idle vector: pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, ALUOp=000.
REQ-016 In an executing state the decode SHALL be:
- Opcode[5]=0 (ALU): ALUOp=Opcode[4:2], s_inm=0, we3=1, wez=1, s_inc=1, pc_en=1.
- Opcode[5:4]=10 (LI): ALUOp=000, s_inm=1, we3=1, wez=0, s_inc=1, pc_en=1.
- 110000 (J): s_inc=0, pc_en=1.
- 110001 (JZ): s_inc=~zero, pc_en=1.
- 110010 (JNZ): s_inc=zero, pc_en=1.
- 111111 (HALT): idle vector.
- Other 11xxxx (NOP): s_inc=1, pc_en=1, no writes.
REQ-017 Decode outputs SHALL be combinational from the registered state and Opcode/zero; there SHALL be zero latency within the cycle.
REQ-018 RST_WAIT SHALL go to RUN if run=1, else to STEP_WAIT, after exactly one cycle.
REQ-019 RUN SHALL go to HALT on a HALT opcode, to STEP_WAIT if run=0, and otherwise stay in RUN; HALT takes priority.
REQ-020 STEP_WAIT SHALL go to RUN if run=1; it SHALL go to STEP_EXEC if step=1 and armed=1; otherwise it stays.
REQ-021 STEP_EXEC SHALL last one cycle with step_ack=1, then go to HALT on a HALT opcode, else to STEP_WAIT; armed SHALL clear on entry and set when step is sampled 0.
REQ-022 The step input SHALL be ignored in RUN, and run changes SHALL be ignored in HALT.
REQ-023 HALT SHALL be exited only by reset, with halted=1 while in it.
REQ-024 instr_cnt SHALL increment by 1 on every cycle with pc_en=1, and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-025 Asserting reset SHALL immediately force RST_WAIT, armed=1, instr_cnt=0, the idle vector, halted=0 and step_ack=0, including mid-step and in HALT.

Configuration
REQ-026 With UC_INSTR_CNT_EN defined, the counter of REQ-024 SHALL be present; without it, instr_cnt SHALL be tied to 0 and no counter flops are built.

Structure
REQ-027 Package uc_pkg SHALL hold the state enum, the opcode constants (OP_J, OP_JZ, OP_JNZ, OP_HALT, the LI prefix) and ALU_PASS_B=3'b000.
REQ-028 The combinational opcode decoder SHALL be the sub-module uc_decode; the FSM, handshake and counter SHALL stay in uc.

Verification
REQ-029 Reset release with run=1 and Opcode=000100 -> one idle cycle, then ALUOp=001, we3=1, wez=1, pc_en=1, and instr_cnt=1 after the edge.
REQ-030 Opcode=110001 with zero=1, then zero=0 -> s_inc=0 (jump), then s_inc=1.
REQ-031 With run=0 and step held high for 3 cycles -> step_ack=1 for exactly one cycle and instr_cnt+1; a second step is accepted only after step returns to 0.
REQ-032 HALT opcode in RUN -> halted=1 from the next cycle, pc_en=0, and toggling run or step has no effect.
REQ-033 instr_cnt preloaded near 0xFFFE with 3 executed instructions -> counter reads 0x0001; without UC_INSTR_CNT_EN it stays 0.
REQ-034 Reset asserted in STEP_EXEC -> outputs are idle asynchronously before the next clk edge and instr_cnt=0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared types and constants for the uc control unit: FSM states, opcode
// encodings and the control-vector record driven to the datapath.
package uc_pkg;

  typedef enum logic [2:0] {
    RST_WAIT  = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    HALT      = 3'd4
  } state_e;

  localparam logic [5:0] OP_J      = 6'b110000;
  localparam logic [5:0] OP_JZ     = 6'b110001;
  localparam logic [5:0] OP_JNZ    = 6'b110010;
  localparam logic [5:0] OP_HALT   = 6'b111111;
  localparam logic [1:0] OP_LI_PFX = 2'b10;

  localparam logic [2:0] ALU_PASS_B = 3'b000;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] alu_op;
    logic       pc_en;
  } ctrl_t;

  // Safe vector: no writes, PC held, next-address mux on the increment path
  localparam ctrl_t CTRL_IDLE = '{
    s_inc:  1'b1,
    s_inm:  1'b0,
    we3:    1'b0,
    wez:    1'b0,
    alu_op: ALU_PASS_B,
    pc_en:  1'b0
  };

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder; emits the idle vector unless the FSM is in
// an executing state.
module uc_decode
  import uc_pkg::*;
(
  input  logic       exec_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    if (exec_i) begin
      if (!opcode_i[5]) begin
        ctrl_o.alu_op = opcode_i[4:2];
        ctrl_o.we3    = 1'b1;
        ctrl_o.wez    = 1'b1;
        ctrl_o.pc_en  = 1'b1;
      end else if (opcode_i[5:4] == OP_LI_PFX) begin
        ctrl_o.alu_op = ALU_PASS_B;
        ctrl_o.s_inm  = 1'b1;
        ctrl_o.we3    = 1'b1;
        ctrl_o.pc_en  = 1'b1;
      end else begin
        case (opcode_i)
          OP_J: begin
            ctrl_o.s_inc = 1'b0;
            ctrl_o.pc_en = 1'b1;
          end
          OP_JZ: begin
            ctrl_o.s_inc = ~zero_i;
            ctrl_o.pc_en = 1'b1;
          end
          OP_JNZ: begin
            ctrl_o.s_inc = zero_i;
            ctrl_o.pc_en = 1'b1;
          end
          OP_HALT: ctrl_o = CTRL_IDLE;
          default: ctrl_o.pc_en = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/uc.sv
// Control unit: run/single-step/halt FSM, step handshake and retired-instruction
// counter (counter built only when UC_INSTR_CNT_EN is defined).
module uc
  import uc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        zero,
  input  logic        run,
  input  logic        step,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  ALUOp,
  output logic        pc_en,
  output logic        halted,
  output logic        step_ack,
  output logic [15:0] instr_cnt
);

  state_e state_q, state_d;
  logic   armed_q, armed_d;
  logic   exec;
  logic   halt_op;
  ctrl_t  ctrl;

  assign halt_op = (Opcode == OP_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RST_WAIT;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    case (state_q)
      RST_WAIT:  state_d = run ? RUN : STEP_WAIT;
      RUN: begin
        if (halt_op)   state_d = HALT;
        else if (!run) state_d = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (run)                  state_d = RUN;
        else if (step && armed_q) state_d = STEP_EXEC;
      end
      STEP_EXEC: state_d = halt_op ? HALT : STEP_WAIT;
      HALT:      state_d = HALT;
      default:   state_d = RST_WAIT;
    endcase
    // A held step level must drop to 0 before another step is accepted
    if (state_q == STEP_WAIT && state_d == STEP_EXEC) armed_d = 1'b0;
    else if (!step)                                   armed_d = 1'b1;
  end

  always_comb begin
    exec     = (state_q == RUN) || (state_q == STEP_EXEC);
    halted   = (state_q == HALT);
    step_ack = (state_q == STEP_EXEC);
  end

  uc_decode u_decode (
    .exec_i   (exec),
    .opcode_i (Opcode),
    .zero_i   (zero),
    .ctrl_o   (ctrl)
  );

  assign s_inc = ctrl.s_inc;
  assign s_inm = ctrl.s_inm;
  assign we3   = ctrl.we3;
  assign wez   = ctrl.wez;
  assign ALUOp = ctrl.alu_op;
  assign pc_en = ctrl.pc_en;

`ifdef UC_INSTR_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = ctrl.pc_en ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_uc.sv
// Self-checking bench for uc: decode vector table plus step, halt, reset and
// counter-wrap sequences, with expected control vectors queued per cycle.
module tb_uc;

  logic        clk;
  logic        reset;
  logic [5:0]  Opcode;
  logic        zero;
  logic        run;
  logic        step;
  logic        s_inc, s_inm, we3, wez, pc_en, halted, step_ack;
  logic [2:0]  ALUOp;
  logic [15:0] instr_cnt;

  uc dut (
    .clk       (clk),
    .reset     (reset),
    .Opcode    (Opcode),
    .zero      (zero),
    .run       (run),
    .step      (step),
    .s_inc     (s_inc),
    .s_inm     (s_inm),
    .we3       (we3),
    .wez       (wez),
    .ALUOp     (ALUOp),
    .pc_en     (pc_en),
    .halted    (halted),
    .step_ack  (step_ack),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] alu;
    logic       pc_en;
    logic       halted;
    logic       ack;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    exp_t       e;
    string      name;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[9];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = 16'd0;
  exp_t        IDLE, HALTED, ALU1, ALU1_ACK;

  function automatic exp_t mk(input logic si, input logic sm, input logic w3, input logic wz,
                              input logic [2:0] a, input logic pe, input logic h, input logic ak);
    exp_t e;
    e = {si, sm, w3, wz, a, pe, h, ak};
    return e;
  endfunction

  function automatic logic [15:0] cnt_exp();
`ifdef UC_INSTR_CNT_EN
    return exp_cnt;
`else
    return 16'd0;
`endif
  endfunction

  task automatic check_out(input string name);
    exp_t act, e;
    n_checks++;
    act = {s_inc, s_inm, we3, wez, ALUOp, pc_en, halted, step_ack};
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got {s_inc,s_inm,we3,wez,alu,pc_en,halted,ack}=%b required %b", name, act, e);
      end else begin
        $display("ok   %s: ctrl=%b", name, act);
      end
    end
  endtask

  task automatic check_cnt(input string name);
    n_checks++;
    if (instr_cnt !== cnt_exp()) begin
      n_fail++;
      $display("FAIL %s: instr_cnt=%h required %h", name, instr_cnt, cnt_exp());
    end
  endtask

  task automatic cycle(input logic [5:0] op, input logic z, input logic r, input logic s,
                       input exp_t e, input string name);
    @(negedge clk);
    Opcode = op;
    zero   = z;
    run    = r;
    step   = s;
    sb_q.push_back(e);
    #2;
    check_out(name);
    @(posedge clk);
    if (e.pc_en) exp_cnt = exp_cnt + 16'd1;
    #1;
    check_cnt({name, "_cnt"});
  endtask

  initial begin
    IDLE     = mk(1, 0, 0, 0, 3'b000, 0, 0, 0);
    HALTED   = mk(1, 0, 0, 0, 3'b000, 0, 1, 0);
    ALU1     = mk(1, 0, 1, 1, 3'b001, 1, 0, 0);
    ALU1_ACK = mk(1, 0, 1, 1, 3'b001, 1, 0, 1);

    vecs[0] = '{6'b000100, 1'b0, ALU1,                              "alu_001"};
    vecs[1] = '{6'b011100, 1'b1, mk(1, 0, 1, 1, 3'b111, 1, 0, 0),   "alu_111"};
    vecs[2] = '{6'b100101, 1'b0, mk(1, 1, 1, 0, 3'b000, 1, 0, 0),   "li"};
    vecs[3] = '{6'b110000, 1'b0, mk(0, 0, 0, 0, 3'b000, 1, 0, 0),   "j"};
    vecs[4] = '{6'b110001, 1'b1, mk(0, 0, 0, 0, 3'b000, 1, 0, 0),   "jz_taken"};
    vecs[5] = '{6'b110001, 1'b0, mk(1, 0, 0, 0, 3'b000, 1, 0, 0),   "jz_not"};
    vecs[6] = '{6'b110010, 1'b1, mk(1, 0, 0, 0, 3'b000, 1, 0, 0),   "jnz_not"};
    vecs[7] = '{6'b110010, 1'b0, mk(0, 0, 0, 0, 3'b000, 1, 0, 0),   "jnz_taken"};
    vecs[8] = '{6'b110101, 1'b0, mk(1, 0, 0, 0, 3'b000, 1, 0, 0),   "nop"};

    reset  = 1'b0;
    run    = 1'b1;
    step   = 1'b0;
    zero   = 1'b0;
    Opcode = 6'b000100;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb_q.push_back(IDLE);
    #2;
    check_out("reset_idle");
    check_cnt("reset_cnt");

    // Release: one idle RST_WAIT cycle, then RUN
    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back(IDLE);
    #2;
    check_out("rst_wait_idle");
    @(posedge clk);
    #1;
    check_cnt("rst_wait_cnt");

    for (int i = 0; i < 9; i++)
      cycle(vecs[i].op, vecs[i].z, 1'b1, 1'b0, vecs[i].e, vecs[i].name);

    // Single-step handshake
    cycle(6'b000100, 0, 0, 0, ALU1,     "run_to_step");
    cycle(6'b000100, 0, 0, 1, IDLE,     "step_wait_req");
    cycle(6'b000100, 0, 0, 1, ALU1_ACK, "step_exec");
    cycle(6'b000100, 0, 0, 1, IDLE,     "step_held1");
    cycle(6'b000100, 0, 0, 1, IDLE,     "step_held2");
    cycle(6'b000100, 0, 0, 0, IDLE,     "step_release");
    cycle(6'b000100, 0, 0, 1, IDLE,     "step_rearm");
    cycle(6'b000100, 0, 0, 0, ALU1_ACK, "step_exec2");
    cycle(6'b000100, 0, 1, 0, IDLE,     "step_to_run");

    // HALT from RUN; run/step ignored afterwards
    cycle(6'b111111, 0, 1, 0, IDLE,   "halt_op");
    cycle(6'b000100, 0, 0, 1, HALTED, "halt_hold1");
    cycle(6'b000100, 0, 1, 0, HALTED, "halt_hold2");
    cycle(6'b000100, 0, 0, 0, HALTED, "halt_hold3");

    // Reset out of HALT
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = 16'd0;
    sb_q.push_back(IDLE);
    #2;
    check_out("halt_reset");
    check_cnt("halt_reset_cnt");

    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    sb_q.push_back(IDLE);
    #2;
    check_out("rst_wait_step");
    cycle(6'b000100, 0, 0, 1, IDLE, "sw_req_b");

    // Asynchronous reset in the middle of STEP_EXEC
    @(negedge clk);
    sb_q.push_back(ALU1_ACK);
    #2;
    check_out("exec_before_rst");
    #1;
    reset = 1'b0;
    exp_cnt = 16'd0;
    #1;
    sb_q.push_back(IDLE);
    check_out("async_rst_idle");
    check_cnt("async_rst_cnt");

    // Counter wrap: free-run ALU instructions through 0xFFFF -> 0x0001
    @(negedge clk);
    reset  = 1'b1;
    run    = 1'b1;
    step   = 1'b0;
    Opcode = 6'b000100;
    @(posedge clk);
`ifdef UC_INSTR_CNT_EN
    for (int i = 0; i < 65537; i++) begin
`else
    for (int i = 0; i < 5; i++) begin
`endif
      @(posedge clk);
      exp_cnt = exp_cnt + 16'd1;
      #1;
      if (exp_cnt == 16'hFFFF) check_cnt("cnt_ffff");
    end
    check_cnt("cnt_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
